// File: rtl/text_console_ctrl.sv
// text_console_ctrl: turns an ASCII valid/ready stream into char_buf writes with cursor, wrap and row/screen clears.
// Define TEXT_CONSOLE_TAB_EN to expand 0x09 into spaces up to the next multiple-of-8 column.
module text_console_ctrl #(
   parameter int COLS       = 80,
   parameter int ROWS       = 40,
   parameter int ADDR_WIDTH = $clog2(COLS*ROWS)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [6:0]               in_char,
   output logic                     cbuf_we,
   output logic [ADDR_WIDTH-1:0]    cbuf_waddr,
   output logic [6:0]               cbuf_wdata,
   input  logic                     cbuf_wdone,
   output logic [$clog2(ROWS)-1:0]  cur_row,
   output logic [$clog2(COLS)-1:0]  cur_col
);
   localparam int RW = $clog2(ROWS);
   localparam int CW = $clog2(COLS);
   localparam int AW = ADDR_WIDTH;

   typedef enum logic [1:0] {IDLE, PUT, CLR_ROW, CLR_ALL} state_t;

   state_t          state, state_n;
   logic            we_n, tab, tab_n, tab_code, accept, printable;
   logic [AW-1:0]   addr_n, row_base, row_last, cur_addr, next_base;
   logic [6:0]      data_n;
   logic [RW-1:0]   row_n, row_inc;
   logic [CW-1:0]   col_n, col_inc;

   assign in_ready  = state == IDLE;
   assign accept    = in_valid && in_ready;
   assign printable = in_char >= 7'h20 && in_char <= 7'h7E;
`ifdef TEXT_CONSOLE_TAB_EN
   assign tab_code  = in_char == 7'h09;
`else
   assign tab_code  = 1'b0;
`endif
   assign row_inc   = (cur_row == RW'(ROWS-1)) ? '0 : cur_row + 1'b1;
   assign col_inc   = cur_col + 1'b1;
   assign row_base  = AW'(cur_row) * AW'(COLS);
   assign row_last  = row_base + AW'(COLS-1);
   assign cur_addr  = row_base + AW'(cur_col);
   assign next_base = AW'(row_inc) * AW'(COLS);

   // Next write/cursor: a write is held until wdone, then one idle cycle decides what follows
   always_comb begin
      state_n = state;
      we_n    = cbuf_we;
      addr_n  = cbuf_waddr;
      data_n  = cbuf_wdata;
      row_n   = cur_row;
      col_n   = cur_col;
      tab_n   = tab;
      if (state == IDLE) begin
         if (accept) begin
            state_n = PUT;
            addr_n  = cur_addr;
            data_n  = 7'h00;
            if (printable || tab_code) begin
               we_n   = 1'b1;
               data_n = tab_code ? 7'h20 : in_char;
               tab_n  = tab_code;
            end else if (in_char == 7'h0A) begin
               state_n = CLR_ROW;
               we_n    = 1'b1;
               addr_n  = next_base;
               row_n   = row_inc;
               col_n   = '0;
            end else if (in_char == 7'h0D) begin
               col_n = '0;
            end else if (in_char == 7'h08 && cur_col != '0) begin
               we_n   = 1'b1;
               addr_n = cur_addr - 1'b1;
               col_n  = cur_col - 1'b1;
            end else if (in_char == 7'h0C) begin
               state_n = CLR_ALL;
               we_n    = 1'b1;
               addr_n  = '0;
            end
         end
      end else if (cbuf_we) begin
         we_n = !cbuf_wdone;
      end else if (state == PUT && cbuf_wdata != '0) begin
         if (cur_col == CW'(COLS-1)) begin
            state_n = CLR_ROW;
            we_n    = 1'b1;
            addr_n  = next_base;
            data_n  = 7'h00;
            row_n   = row_inc;
            col_n   = '0;
            tab_n   = 1'b0;
         end else begin
            col_n = col_inc;
            if (tab && col_inc[2:0] != 3'd0) begin
               we_n   = 1'b1;
               addr_n = cbuf_waddr + 1'b1;
            end else begin
               state_n = IDLE;
               tab_n   = 1'b0;
            end
         end
      end else if ((state == CLR_ROW && cbuf_waddr != row_last) ||
                   (state == CLR_ALL && cbuf_waddr != AW'(COLS*ROWS-1))) begin
         we_n   = 1'b1;
         addr_n = cbuf_waddr + 1'b1;
      end else begin
         state_n = IDLE;
         tab_n   = 1'b0;
         if (state == CLR_ALL) begin
            row_n = '0;
            col_n = '0;
         end
      end
   end

   // State, registered write port and cursor; reset abandons any write sequence in flight
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         cbuf_we    <= 1'b0;
         cbuf_waddr <= '0;
         cbuf_wdata <= '0;
         cur_row    <= '0;
         cur_col    <= '0;
         tab        <= 1'b0;
      end else begin
         state      <= state_n;
         cbuf_we    <= we_n;
         cbuf_waddr <= addr_n;
         cbuf_wdata <= data_n;
         cur_row    <= row_n;
         cur_col    <= col_n;
         tab        <= tab_n;
      end
   end
endmodule

// File: tb/tb_text_console_ctrl.sv
// tb_text_console_ctrl: randomized bench for text_console_ctrl against a screen/cursor model.
module tb_text_console_ctrl;
   logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_ready, cbuf_we, cbuf_wdone = 1'b0;
   logic [6:0]  in_char = 7'h00, cbuf_wdata;
   logic [11:0] cbuf_waddr;
   logic [5:0]  cur_row;
   logic [6:0]  cur_col;
   int          vectors = 0, miscompares = 0, done_pct = 50;
   int          got_q[$], exp_q[$];
   int          m_row = 0, m_col = 0;
   bit          prev_we = 0, prev_done = 0;
   logic [11:0] prev_addr;
   logic [6:0]  prev_data;

   always #5 clk = ~clk;

   text_console_ctrl dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_char(in_char),
      .cbuf_we(cbuf_we), .cbuf_waddr(cbuf_waddr), .cbuf_wdata(cbuf_wdata), .cbuf_wdone(cbuf_wdone),
      .cur_row(cur_row), .cur_col(cur_col)
   );

   // char_buf stand-in: random write latency, records completed writes, checks hold and gap rules
   always @(negedge clk) begin
      if (rst) begin
         prev_we = 0;
         prev_done = 0;
         cbuf_wdone = 1'b0;
      end else begin
         if (prev_we && !prev_done) begin
            vectors++;
            if (!cbuf_we || cbuf_waddr !== prev_addr || cbuf_wdata !== prev_data) begin
               miscompares++;
               $display("FAIL write_hold: got we=%b addr=%0d data=%h, expected we=1 addr=%0d data=%h",
                        cbuf_we, cbuf_waddr, cbuf_wdata, prev_addr, prev_data);
            end
         end
         if (prev_we && prev_done) begin
            vectors++;
            if (cbuf_we !== 1'b0) begin
               miscompares++;
               $display("FAIL write_gap: got we=%b after wdone, expected 0", cbuf_we);
            end
         end
         cbuf_wdone = cbuf_we && ($urandom_range(0, 99) < done_pct);
         if (cbuf_wdone) got_q.push_back(int'(cbuf_waddr) * 128 + int'(cbuf_wdata));
         prev_we = cbuf_we;
         prev_done = cbuf_wdone;
         prev_addr = cbuf_waddr;
         prev_data = cbuf_wdata;
      end
   end

   function automatic void m_newline();
      m_col = 0;
      m_row = (m_row + 1) % 40;
      for (int c = 0; c < 80; c++) exp_q.push_back((m_row * 80 + c) * 128);
   endfunction

   function automatic void m_put(int d);
      exp_q.push_back((m_row * 80 + m_col) * 128 + d);
      if (m_col == 79) m_newline();
      else m_col++;
   endfunction

   function automatic void model(int ch);
      if (ch >= 32 && ch <= 126) m_put(ch);
      else if (ch == 10) m_newline();
      else if (ch == 13) m_col = 0;
      else if (ch == 8) begin
         if (m_col > 0) begin
            m_col--;
            exp_q.push_back((m_row * 80 + m_col) * 128);
         end
      end else if (ch == 12) begin
         for (int a = 0; a < 3200; a++) exp_q.push_back(a * 128);
         m_row = 0;
         m_col = 0;
      end
`ifdef TEXT_CONSOLE_TAB_EN
      else if (ch == 9) begin
         do m_put(32); while (m_col % 8 != 0);
      end
`endif
   endfunction

   task automatic send(input int ch, output bit dropped, output bit ok);
      int n = 0;
      @(negedge clk);
      in_valid = 1'b1;
      in_char = 7'(ch);
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
      in_char = 7'($urandom);
      @(negedge clk);
      dropped = !in_ready;
      n = 0;
      while (!in_ready && n < 20000) begin
         @(negedge clk);
         n++;
      end
      ok = in_ready;
      model(ch);
   endtask

   task automatic send_n(input int ch, input int cnt, output bit ok);
      bit d, o;
      ok = 1;
      for (int i = 0; i < cnt; i++) begin
         send(ch, d, o);
         ok &= o;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 rst = 1'b1;
      got_q.delete();
      exp_q.delete();
      m_row = 0;
      m_col = 0;
      @(negedge clk);
      #2 rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      vectors++;
      if ({in_ready, cbuf_we} !== 2'b10) begin
         miscompares++;
         $display("FAIL reset_handshake: got ready=%b we=%b, expected ready=1 we=0", in_ready, cbuf_we);
      end
      vectors++;
      if (cbuf_waddr !== 12'd0 || cbuf_wdata !== 7'd0) begin
         miscompares++;
         $display("FAIL reset_port: got addr=%0d data=%h, expected 0 0", cbuf_waddr, cbuf_wdata);
      end
      vectors++;
      if ({cur_row, cur_col} !== 13'd0) begin
         miscompares++;
         $display("FAIL reset_cursor: got (%0d,%0d), expected (0,0)", cur_row, cur_col);
      end
      #2 rst = 1'b0;
   endtask

   task automatic test_print();
      bit d, o;
      do_reset();
      send(8'h41, d, o);
      vectors++;
      if (!d || !o) begin
         miscompares++;
         $display("FAIL print_ready: got dropped=%b returned=%b, expected 1 1", d, o);
      end
      vectors++;
      if (got_q.size() !== 1 || got_q[0] !== 'h41) begin
         miscompares++;
         $display("FAIL print_write: got %0d writes first=%0d, expected 1 write addr 0 data 41", got_q.size(),
                  got_q.size() > 0 ? got_q[0] : -1);
      end
      vectors++;
      if ({cur_row, cur_col} !== {6'd0, 7'd1}) begin
         miscompares++;
         $display("FAIL print_cursor: got (%0d,%0d), expected (0,1)", cur_row, cur_col);
      end
   endtask

   task automatic test_line_wrap();
      bit o, bad = 0;
      do_reset();
      send_n(8'h42, 80, o);
      vectors++;
      if (got_q.size() !== 160 || !o) begin
         miscompares++;
         $display("FAIL wrap_count: got %0d writes ok=%b, expected 160 ok=1", got_q.size(), o);
      end else for (int i = 0; i < 160 && !bad; i++) if (got_q[i] !== (i < 80 ? i * 128 + 'h42 : i * 128)) begin
         bad = 1;
         miscompares++;
         $display("FAIL wrap_write %0d: got addr %0d data %h, expected addr %0d data %h", i, got_q[i] / 128,
                  got_q[i] % 128, i, i < 80 ? 'h42 : 0);
      end
      vectors++;
      if ({cur_row, cur_col} !== {6'd1, 7'd0}) begin
         miscompares++;
         $display("FAIL wrap_cursor: got (%0d,%0d), expected (1,0)", cur_row, cur_col);
      end
   endtask

   task automatic test_newline_cr();
      bit d, o, o2, bad = 0;
      do_reset();
      done_pct = 100;
      send_n(8'h0A, 39, o);
      send_n(8'h61, 10, o2);
      got_q.delete();
      exp_q.delete();
      done_pct = 50;
      send(8'h0A, d, o);
      vectors++;
      if (got_q.size() !== 80 || !o) begin
         miscompares++;
         $display("FAIL lf_wrap_count: got %0d writes ok=%b, expected 80 ok=1", got_q.size(), o);
      end else for (int i = 0; i < 80 && !bad; i++) if (got_q[i] !== exp_q[i]) begin
         bad = 1;
         miscompares++;
         $display("FAIL lf_wrap_write %0d: got addr %0d data %h, expected addr %0d data %h", i,
                  got_q[i] / 128, got_q[i] % 128, exp_q[i] / 128, exp_q[i] % 128);
      end
      vectors++;
      if ({cur_row, cur_col} !== 13'd0) begin
         miscompares++;
         $display("FAIL lf_wrap_cursor: got (%0d,%0d), expected (0,0)", cur_row, cur_col);
      end
      do_reset();
      done_pct = 100;
      send_n(8'h0A, 3, o);
      send_n(8'h62, 7, o);
      got_q.delete();
      done_pct = 50;
      send(8'h0D, d, o);
      vectors++;
      if (got_q.size() !== 0 || !d || !o) begin
         miscompares++;
         $display("FAIL cr: got %0d writes dropped=%b ok=%b, expected 0 1 1", got_q.size(), d, o);
      end
      vectors++;
      if ({cur_row, cur_col} !== {6'd3, 7'd0}) begin
         miscompares++;
         $display("FAIL cr_cursor: got (%0d,%0d), expected (3,0)", cur_row, cur_col);
      end
   endtask

   task automatic test_backspace();
      bit d, o;
      do_reset();
      done_pct = 100;
      send_n(8'h0A, 2, o);
      send_n(8'h63, 5, o);
      got_q.delete();
      done_pct = 50;
      send(8'h08, d, o);
      vectors++;
      if (got_q.size() !== 1 || got_q[0] !== 164 * 128) begin
         miscompares++;
         $display("FAIL bs_write: got %0d writes first=%0d, expected 1 write addr 164 data 00", got_q.size(),
                  got_q.size() > 0 ? got_q[0] : -1);
      end
      vectors++;
      if ({cur_row, cur_col} !== {6'd2, 7'd4}) begin
         miscompares++;
         $display("FAIL bs_cursor: got (%0d,%0d), expected (2,4)", cur_row, cur_col);
      end
      send(8'h0D, d, o);
      got_q.delete();
      send(8'h08, d, o);
      vectors++;
      if (got_q.size() !== 0 || {cur_row, cur_col} !== {6'd2, 7'd0}) begin
         miscompares++;
         $display("FAIL bs_col0: got %0d writes cursor (%0d,%0d), expected 0 writes (2,0)", got_q.size(),
                  cur_row, cur_col);
      end
   endtask

   task automatic test_clear_all();
      bit d, o, bad = 0;
      do_reset();
      send(8'h5A, d, o);
      got_q.delete();
      exp_q.delete();
      send(8'h0C, d, o);
      vectors++;
      if (got_q.size() !== 3200 || !d || !o) begin
         miscompares++;
         $display("FAIL ff_count: got %0d writes dropped=%b ok=%b, expected 3200 1 1", got_q.size(), d, o);
      end else for (int i = 0; i < 3200 && !bad; i++) if (got_q[i] !== exp_q[i]) begin
         bad = 1;
         miscompares++;
         $display("FAIL ff_write %0d: got addr %0d data %h, expected addr %0d data 00", i, got_q[i] / 128,
                  got_q[i] % 128, exp_q[i] / 128);
      end
      vectors++;
      if ({cur_row, cur_col} !== 13'd0) begin
         miscompares++;
         $display("FAIL ff_cursor: got (%0d,%0d), expected (0,0)", cur_row, cur_col);
      end
   endtask

   task automatic test_reset_mid_clear();
      bit d, o;
      do_reset();
      send(8'h5A, d, o);
      @(negedge clk);
      in_valid = 1'b1;
      in_char = 7'h0C;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (200) @(negedge clk);
      vectors++;
      if (in_ready !== 1'b0 || {cur_row, cur_col} !== {6'd0, 7'd1}) begin
         miscompares++;
         $display("FAIL mid_clear_busy: got ready=%b cursor (%0d,%0d), expected 0 (0,1)", in_ready, cur_row, cur_col);
      end
      #2 rst = 1'b1;
      #1;
      vectors++;
      if (cbuf_we !== 1'b0 || in_ready !== 1'b1 || {cur_row, cur_col} !== 13'd0) begin
         miscompares++;
         $display("FAIL mid_clear_reset: got we=%b ready=%b cursor (%0d,%0d), expected 0 1 (0,0)", cbuf_we,
                  in_ready, cur_row, cur_col);
      end
      @(negedge clk);
      #2 rst = 1'b0;
      got_q.delete();
      exp_q.delete();
      m_row = 0;
      m_col = 0;
   endtask

   task automatic test_tab();
      bit d, o, bad = 0;
      do_reset();
      send_n(8'h64, 3, o);
      got_q.delete();
      exp_q.delete();
      send(8'h09, d, o);
      vectors++;
      if (got_q.size() !== exp_q.size() || !d || !o) begin
         miscompares++;
         $display("FAIL tab_count: got %0d writes dropped=%b ok=%b, expected %0d 1 1", got_q.size(), d, o,
                  exp_q.size());
      end else foreach (exp_q[i]) if (!bad && got_q[i] !== exp_q[i]) begin
         bad = 1;
         miscompares++;
         $display("FAIL tab_write %0d: got addr %0d data %h, expected addr %0d data %h", i, got_q[i] / 128,
                  got_q[i] % 128, exp_q[i] / 128, exp_q[i] % 128);
      end
      vectors++;
`ifdef TEXT_CONSOLE_TAB_EN
      if ({cur_row, cur_col} !== {6'd0, 7'd8}) begin
`else
      if ({cur_row, cur_col} !== {6'd0, 7'd3}) begin
`endif
         miscompares++;
         $display("FAIL tab_cursor: got (%0d,%0d), model (%0d,%0d)", cur_row, cur_col, m_row, m_col);
      end
   endtask

   task automatic test_random();
      bit d, o, bad;
      int ch;
      do_reset();
      for (int n = 0; n < 300; n++) begin
         done_pct = ($urandom_range(0, 3) == 0) ? 100 : $urandom_range(20, 90);
         case ($urandom_range(0, 9))
            5:       ch = 8'h0A;
            6:       ch = 8'h0D;
            7, 8:    ch = 8'h08;
            9:       ch = ($urandom_range(0, 1) == 0) ? 8'h09 : $urandom_range(0, 31);
            default: ch = $urandom_range(32, 127);
         endcase
         if (ch == 12) ch = 8'h7F;
         got_q.delete();
         exp_q.delete();
         send(ch, d, o);
         bad = got_q.size() !== exp_q.size() || !o;
         foreach (exp_q[i]) if (!bad && got_q[i] !== exp_q[i]) bad = 1;
         vectors++;
         if (bad) begin
            miscompares++;
            $display("FAIL random char %h #%0d: got %0d writes ok=%b, expected %0d writes (first diff or count)",
                     ch, n, got_q.size(), o, exp_q.size());
         end
         vectors++;
         if ({cur_row, cur_col} !== {6'(m_row), 7'(m_col)}) begin
            miscompares++;
            $display("FAIL random_cursor char %h #%0d: got (%0d,%0d), expected (%0d,%0d)", ch, n, cur_row,
                     cur_col, m_row, m_col);
         end
      end
      done_pct = 50;
   endtask

   initial begin
      test_reset();
      test_print();
      test_line_wrap();
      test_newline_cr();
      test_backspace();
      test_clear_all();
      test_reset_mid_clear();
      test_tab();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
